// File: rtl/t5_lsu_if.sv
// Data-bus interface between the t5 load/store stage (master) and memory (slave).
// stb/cyc carry the request; the request fields stay stable until the slave's ack.
interface t5_lsu_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] dwb_adr;
    logic [XLEN-1:0] dwb_dat_o;
    logic [XLEN-1:0] dwb_dat_i;
    logic [3:0]      dwb_sel;
    logic            dwb_we;
    logic            dwb_stb;
    logic            dwb_cyc;
    logic            dwb_ack;

    modport master (
        output dwb_adr, dwb_dat_o, dwb_sel, dwb_we, dwb_stb, dwb_cyc,
        input  dwb_dat_i, dwb_ack
    );

    modport slave (
        input  dwb_adr, dwb_dat_o, dwb_sel, dwb_we, dwb_stb, dwb_cyc,
        output dwb_dat_i, dwb_ack
    );
endinterface

// File: rtl/t5_lsu.sv
// t5 memory-access stage: one bus transaction per load/store, aligned and extended
// load result, stall while a transaction is outstanding.
module t5_lsu #(
    parameter int XLEN = 32
) (
    input  logic            sclk,
    input  logic            srst_n,
    input  logic            sena,
    input  logic [6:2]      xopc,
    input  logic [14:12]    xfn3,
    input  logic [XLEN-1:0] xbpc,
    input  logic [XLEN-1:0] xdat,
    t5_lsu_if.master        dwb,
    output logic            dstl,
    output logic [XLEN-1:0] mdat,
    output logic [6:2]      mopc,
    output logic [14:12]    mfn3,
    output logic            mexc,
    output logic            dbg_state
);
    localparam logic [6:2] OP_LOAD  = 5'h00;
    localparam logic [6:2] OP_STORE = 5'h08;
    localparam logic [6:2] OP_RST   = 5'h0D;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] adr_q, adr_d;
    logic [XLEN-1:0] dat_o_q, dat_o_d;
    logic [XLEN-1:0] mdat_q, mdat_d;
    logic [1:0]      lo_q, lo_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            stb_q, stb_d;
    logic            mexc_q, mexc_d;
    logic [6:2]      mopc_q, mopc_d;
    logic [14:12]    mfn3_q, mfn3_d;

    logic            is_load, is_store, fn3_ok, misaligned, capture;
    logic [3:0]      sel_new;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;

    // Decode of the execute-stage op being offered for capture.
    always_comb begin
        is_load  = (xopc == OP_LOAD);
        is_store = (xopc == OP_STORE);
        fn3_ok   = 1'b0;
        case (xfn3)
            3'b000, 3'b001, 3'b010: fn3_ok = is_load | is_store;
            3'b100, 3'b101:         fn3_ok = is_load;
            default:                fn3_ok = 1'b0;
        endcase
        misaligned = ((xfn3[13:12] == 2'b01) && xbpc[0]) ||
                     ((xfn3[13:12] == 2'b10) && (xbpc[1:0] != 2'b00));
        case (xfn3[13:12])
            2'b00:   sel_new = 4'b0001 << xbpc[1:0];
            2'b01:   sel_new = xbpc[1] ? 4'b1100 : 4'b0011;
            default: sel_new = 4'b1111;
        endcase
        // The ack edge frees the stage, so a new op may be taken there too.
        capture = sena & ((state_q == IDLE) | dwb.dwb_ack);
    end

    // Lane extraction uses the low address bits kept aside from the aligned bus address.
    always_comb begin
        case (lo_q)
            2'd0:    ld_byte = dwb.dwb_dat_i[7:0];
            2'd1:    ld_byte = dwb.dwb_dat_i[15:8];
            2'd2:    ld_byte = dwb.dwb_dat_i[23:16];
            default: ld_byte = dwb.dwb_dat_i[31:24];
        endcase
        ld_half = lo_q[1] ? dwb.dwb_dat_i[31:16] : dwb.dwb_dat_i[15:0];
        case (mfn3_q)
            3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_val = dwb.dwb_dat_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_o_d = dat_o_q;
        mdat_d  = mdat_q;
        lo_d    = lo_q;
        sel_d   = sel_q;
        we_d    = we_q;
        stb_d   = stb_q;
        mopc_d  = mopc_q;
        mfn3_d  = mfn3_q;
        mexc_d  = 1'b0;

        if ((state_q == BUSY) && dwb.dwb_ack) begin
            state_d = IDLE;
            stb_d   = 1'b0;
            sel_d   = 4'b0000;
            if (!we_q) begin
                mdat_d = ld_val;
            end
        end

        if (capture) begin
            mopc_d = xopc;
            mfn3_d = xfn3;
            if (is_load || is_store) begin
                if (!fn3_ok || misaligned) begin
                    mexc_d = 1'b1;
                end else begin
                    state_d = BUSY;
                    stb_d   = 1'b1;
                    adr_d   = {xbpc[XLEN-1:2], 2'b00};
                    lo_d    = xbpc[1:0];
                    we_d    = is_store;
                    dat_o_d = xdat;
                    sel_d   = sel_new;
                end
            end
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_o_q <= '0;
            mdat_q  <= '0;
            lo_q    <= 2'b00;
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            mexc_q  <= 1'b0;
            mopc_q  <= OP_RST;
            mfn3_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_o_q <= dat_o_d;
            mdat_q  <= mdat_d;
            lo_q    <= lo_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            mexc_q  <= mexc_d;
            mopc_q  <= mopc_d;
            mfn3_q  <= mfn3_d;
        end
    end

    assign dwb.dwb_adr   = adr_q;
    assign dwb.dwb_dat_o = dat_o_q;
    assign dwb.dwb_sel   = sel_q;
    assign dwb.dwb_we    = we_q;
    assign dwb.dwb_stb   = stb_q;
    assign dwb.dwb_cyc   = stb_q;
    assign dstl          = stb_q & ~dwb.dwb_ack;
    assign mdat          = mdat_q;
    assign mopc          = mopc_q;
    assign mfn3          = mfn3_q;
    assign mexc          = mexc_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_t5_lsu.sv
// Bench for t5_lsu: directed cases plus random ops, checked against a size/offset
// arithmetic model of the memory stage.
module tb_t5_lsu;
    logic          sclk = 1'b0;
    logic          srst_n;
    logic          sena;
    logic [6:2]    xopc;
    logic [14:12]  xfn3;
    logic [31:0]   xbpc;
    logic [31:0]   xdat;
    logic          dstl;
    logic [31:0]   mdat;
    logic [6:2]    mopc;
    logic [14:12]  mfn3;
    logic          mexc;
    logic          dbg_state;

    t5_lsu_if #(.XLEN(32)) dwb ();

    t5_lsu #(.XLEN(32)) dut (
        .sclk      (sclk),
        .srst_n    (srst_n),
        .sena      (sena),
        .xopc      (xopc),
        .xfn3      (xfn3),
        .xbpc      (xbpc),
        .xdat      (xdat),
        .dwb       (dwb),
        .dstl      (dstl),
        .mdat      (mdat),
        .mopc      (mopc),
        .mfn3      (mfn3),
        .mexc      (mexc),
        .dbg_state (dbg_state)
    );

    always #5 sclk = ~sclk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mdat;
    logic [4:0]  model_mopc;
    logic [2:0]  model_fn3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: legality, lane mask and load value from access size and offset.
    function automatic bit ref_is_mem(input logic [4:0] opc);
        return (opc == 5'h00) || (opc == 5'h08);
    endfunction

    function automatic bit ref_fault(input logic [4:0] opc, input logic [2:0] fn3,
                                     input logic [31:0] addr);
        int  nbytes = 1 << fn3[1:0];
        bit  legal  = 1'b0;
        if (opc == 5'h00) legal = (fn3 == 0) || (fn3 == 1) || (fn3 == 2) || (fn3 == 4) || (fn3 == 5);
        if (opc == 5'h08) legal = (fn3 <= 2);
        return !legal || ((addr % nbytes) != 0);
    endfunction

    function automatic logic [3:0] ref_sel(input logic [2:0] fn3, input logic [31:0] addr);
        int nbytes = 1 << fn3[1:0];
        int s      = ((1 << nbytes) - 1) << (addr % 4);
        return s[3:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] fn3, input logic [31:0] addr,
                                             input logic [31:0] rdat);
        int          nbytes = 1 << fn3[1:0];
        logic [31:0] v      = rdat >> (8 * (addr % 4));
        logic [31:0] mask;
        if (nbytes < 4) begin
            mask = (32'd1 << (8 * nbytes)) - 32'd1;
            v    = v & mask;
            if (!fn3[2] && v[8*nbytes-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Issue one op with sena for one cycle; slave acks after 'waits' wait states.
    task automatic run_op(input logic [4:0] opc, input logic [2:0] fn3, input logic [31:0] addr,
                          input logic [31:0] wdat, input logic [31:0] rdat, input int waits);
        xopc = opc; xfn3 = fn3; xbpc = addr; xdat = wdat; sena = 1'b1;
        @(posedge sclk); #1;
        sena = 1'b0;
        model_mopc = opc;
        model_fn3  = fn3;
        chk("mopc", 32'(mopc), 32'(model_mopc));
        chk("mfn3", 32'(mfn3), 32'(model_fn3));
        if (ref_is_mem(opc) && !ref_fault(opc, fn3, addr)) begin
            if (opc == 5'h00) exp_q.push_back(ref_load(fn3, addr, rdat));
            for (int w = 0; w <= waits; w++) begin
                chk("stb", 32'(dwb.dwb_stb), 1);
                chk("cyc", 32'(dwb.dwb_cyc), 1);
                chk("adr", dwb.dwb_adr, {addr[31:2], 2'b00});
                chk("sel", 32'(dwb.dwb_sel), 32'(ref_sel(fn3, addr)));
                chk("we", 32'(dwb.dwb_we), 32'(opc == 5'h08));
                if (opc == 5'h08) chk("dat_o", dwb.dwb_dat_o, wdat);
                chk("mexc_busy", 32'(mexc), 0);
                if (w == waits) begin
                    dwb.dwb_ack = 1'b1;
                    dwb.dwb_dat_i = rdat;
                end else begin
                    dwb.dwb_dat_i = $urandom;
                end
                #1;
                chk("dstl", 32'(dstl), 32'(w != waits));
                @(posedge sclk); #1;
            end
            dwb.dwb_ack = 1'b0;
            chk("stb_done", 32'(dwb.dwb_stb), 0);
            chk("sel_idle", 32'(dwb.dwb_sel), 0);
            if (opc == 5'h00) model_mdat = exp_q.pop_front();
            chk("mdat", mdat, model_mdat);
        end else begin
            chk("stb_none", 32'(dwb.dwb_stb), 0);
            chk("mexc", 32'(mexc), 32'(ref_is_mem(opc)));
            chk("mdat_hold", mdat, model_mdat);
            @(posedge sclk); #1;
            chk("mexc_clr", 32'(mexc), 0);
        end
    endtask

    task automatic idle_hold();
        xopc = 5'($urandom); xfn3 = 3'($urandom); xbpc = $urandom; sena = 1'b0;
        @(posedge sclk); #1;
        chk("hold_mopc", 32'(mopc), 32'(model_mopc));
        chk("hold_stb", 32'(dwb.dwb_stb), 0);
        chk("hold_mexc", 32'(mexc), 0);
    endtask

    task automatic back_to_back();
        logic [31:0] rdat = 32'hCAFEF00D;
        xopc = 5'h08; xfn3 = 3'b010; xbpc = 32'h10; xdat = 32'h11223344; sena = 1'b1;
        @(posedge sclk); #1;
        chk("b2b_sw_stb", 32'(dwb.dwb_stb), 1);
        chk("b2b_sw_adr", dwb.dwb_adr, 32'h10);
        chk("b2b_sw_we", 32'(dwb.dwb_we), 1);
        chk("b2b_sw_dat", dwb.dwb_dat_o, 32'h11223344);
        dwb.dwb_ack = 1'b1; dwb.dwb_dat_i = $urandom;
        xopc = 5'h00; xfn3 = 3'b010; xbpc = 32'h14;
        #1;
        chk("b2b_dstl0", 32'(dstl), 0);
        @(posedge sclk); #1;
        sena = 1'b0;
        chk("b2b_lw_stb", 32'(dwb.dwb_stb), 1);
        chk("b2b_lw_adr", dwb.dwb_adr, 32'h14);
        chk("b2b_lw_we", 32'(dwb.dwb_we), 0);
        chk("b2b_lw_mopc", 32'(mopc), 0);
        dwb.dwb_dat_i = rdat;
        #1;
        chk("b2b_dstl1", 32'(dstl), 0);
        @(posedge sclk); #1;
        dwb.dwb_ack = 1'b0;
        chk("b2b_stb_end", 32'(dwb.dwb_stb), 0);
        model_mdat = rdat; model_mopc = 5'h00; model_fn3 = 3'b010;
        chk("b2b_mdat", mdat, model_mdat);
    endtask

    task automatic reset_abort();
        xopc = 5'h00; xfn3 = 3'b010; xbpc = 32'h400; sena = 1'b1;
        @(posedge sclk); #1;
        sena = 1'b0;
        chk("rst_pre_stb", 32'(dwb.dwb_stb), 1);
        #2 srst_n = 1'b0;
        #1;
        chk("rst_stb", 32'(dwb.dwb_stb), 0);
        chk("rst_cyc", 32'(dwb.dwb_cyc), 0);
        chk("rst_mopc", 32'(mopc), 32'h0D);
        chk("rst_mdat", mdat, 0);
        @(posedge sclk); #1;
        srst_n = 1'b1;
        model_mdat = '0; model_mopc = 5'h0D; model_fn3 = 3'b000;
        exp_q.delete();
        dwb.dwb_ack = 1'b1; dwb.dwb_dat_i = 32'h12345678;
        @(posedge sclk); #1;
        dwb.dwb_ack = 1'b0;
        chk("stray_stb", 32'(dwb.dwb_stb), 0);
        chk("stray_mdat", mdat, 0);
        chk("stray_mopc", 32'(mopc), 32'h0D);
    endtask

    initial begin
        srst_n = 1'b0; sena = 1'b0; xopc = 5'h04; xfn3 = 3'b000; xbpc = '0; xdat = '0;
        dwb.dwb_ack = 1'b0; dwb.dwb_dat_i = '0;
        model_mdat = '0; model_mopc = 5'h0D; model_fn3 = 3'b000;
        repeat (2) @(posedge sclk);
        #1;
        chk("rst0_stb", 32'(dwb.dwb_stb), 0);
        chk("rst0_cyc", 32'(dwb.dwb_cyc), 0);
        chk("rst0_we", 32'(dwb.dwb_we), 0);
        chk("rst0_sel", 32'(dwb.dwb_sel), 0);
        chk("rst0_adr", dwb.dwb_adr, 0);
        chk("rst0_dat_o", dwb.dwb_dat_o, 0);
        chk("rst0_mdat", mdat, 0);
        chk("rst0_mopc", 32'(mopc), 32'h0D);
        chk("rst0_mfn3", 32'(mfn3), 0);
        chk("rst0_mexc", 32'(mexc), 0);
        chk("rst0_dstl", 32'(dstl), 0);
        srst_n = 1'b1;
        @(posedge sclk); #1;

        run_op(5'h00, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_op(5'h00, 3'b000, 32'h203, 32'h0, 32'h80FF0011, 0);
        run_op(5'h00, 3'b100, 32'h203, 32'h0, 32'h80FF0011, 1);
        run_op(5'h08, 3'b001, 32'h302, 32'hABCDABCD, 32'h0, 3);
        run_op(5'h00, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        run_op(5'h00, 3'b001, 32'h103, 32'h0, 32'h0, 0);
        run_op(5'h00, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        run_op(5'h08, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        run_op(5'h04, 3'b000, 32'h100, 32'h0, 32'h0, 0);
        idle_hold();
        back_to_back();
        reset_abort();

        for (int i = 0; i < 80; i++) begin
            logic [4:0] opc;
            int         kind = $urandom_range(0, 3);
            if (kind <= 1)      opc = 5'h00;
            else if (kind == 2) opc = 5'h08;
            else                opc = 5'h0C;
            run_op(opc, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) idle_hold();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/t5_lsu.md
# t5_lsu

Memory-access stage of the t5 pipeline, directly downstream of the ALU/shift stage. It captures the execute-stage opcode, funct3, effective address (`xbpc`) and lane-replicated store data (`xdat`), runs one data-bus transaction per load/store, and produces an aligned, sign- or zero-extended load result. While a bus transaction is outstanding it raises a stall that the pipeline uses to drop `sena`.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `sclk` in 1: clock, rising edge.
- `srst_n` in 1: asynchronous, active-low reset.
- `sena` in 1: pipeline enable; inputs are captured only when high.
- `xopc` in [6:2]: execute-stage opcode. `5'h00` is LOAD, `5'h08` is STORE, anything else is a non-memory op.
- `xfn3` in [14:12]: execute-stage funct3 (access size and signedness).
- `xbpc` in XLEN: effective address.
- `xdat` in XLEN: store data, already replicated across byte lanes.
- `dwb_adr` out XLEN: bus address, word-aligned (`[1:0]=0`).
- `dwb_dat_o` out XLEN: bus write data.
- `dwb_sel` out 4: byte-lane enables.
- `dwb_we` out 1: write strobe qualifier.
- `dwb_stb` out 1: request strobe.
- `dwb_cyc` out 1: bus cycle; equal to `dwb_stb`.
- `dwb_dat_i` in XLEN: bus read data.
- `dwb_ack` in 1: transfer acknowledge; sampled only while `dwb_stb=1`.
- `dstl` out 1: stall, combinational, `dwb_stb & ~dwb_ack`.
- `mdat` out XLEN: load result.
- `mopc` out [6:2]: opcode of the instruction in the M stage.
- `mfn3` out [14:12]: funct3 of the instruction in the M stage.
- `mexc` out 1: misaligned or illegal-access exception, one cycle per instruction.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - BUSY: `dwb_stb`/`dwb_cyc` high, waiting for `dwb_ack`.
- Capture in IDLE with `sena=1`, on the rising edge:
  - `mopc<=xopc`, `mfn3<=xfn3`.
  - Latch the address, store data and access size internally.
- Access legality:
  - Legal funct3 for LOAD: 000, 001, 010, 100, 101.
  - Legal funct3 for STORE: 000, 001, 010.
  - Misaligned: a halfword with `xbpc[0]=1`, or a word with `xbpc[1:0]!=0`.
- Legal, aligned memory op:
  - Go to BUSY.
  - `dwb_adr={xbpc[31:2],2'b00}`, `dwb_we=(xopc==5'h08)`, `dwb_dat_o=xdat`.
- Illegal or misaligned memory op:
  - No bus request; stay in IDLE.
  - `mexc<=1` for one cycle; `mdat` holds its value.
- Non-memory op: no bus activity; `mexc<=0`.
- `dwb_sel`:
  - Byte: `4'b0001<<adr[1:0]`.
  - Half: `adr[1] ? 4'b1100 : 4'b0011`.
  - Word: `4'b1111`.
  - Forced to 0 when idle.
- BUSY with `dwb_ack=1`:
  - Deassert `dwb_stb`/`dwb_cyc` at the edge and return to IDLE.
  - For a load, register the extracted value into `mdat` at that same edge.
- Load extraction (lane selected by `adr[1:0]`):
  - LB / LBU: byte lane `adr[1:0]`; sign-extended (LB) or zero-extended (LBU).
  - LH / LHU: half `adr[1]`; sign-extended (LH) or zero-extended (LHU).
  - LW: full word.
- Stores leave `mdat` unchanged.
- While BUSY, `sena` is ignored: upstream holds its values because `dstl` drops `sena`.

## Timing
- Reset (async, `srst_n=0`):
  - State IDLE.
  - `dwb_stb=0`, `dwb_cyc=0`, `dwb_we=0`, `dwb_sel=0`.
  - `dwb_adr=0`, `dwb_dat_o=0`, `mdat=0`.
  - `mopc=5'h0D`, `mfn3=0`, `mexc=0`.
- Reset during BUSY aborts the transaction at once; a later stray `dwb_ack` with `dwb_stb=0` is ignored.
- Request timing: capture at edge k, so `dwb_stb` is high from cycle k+1.
- Zero-wait ack (ack in cycle k+1):
  - `dstl=0`, so the pipeline advances at edge k+2.
  - `mdat` is valid after edge k+2.
- N wait states: `dstl=1` for N cycles, and the result is valid one edge after the ack cycle.
- Back-to-back memory ops: the next capture can occur at the ack edge, giving one request per cycle at full throughput.
- `dwb_adr`, `dwb_we`, `dwb_sel` and `dwb_dat_o` stay stable throughout BUSY.
- `sena=0` in IDLE: hold all registers; `mexc` clears.

## Test plan
- LW, `xbpc=0x100`, bus returns `0xDEADBEEF` with zero wait → `dwb_sel=1111`, `dwb_we=0`, `dstl=0`, `mdat=0xDEADBEEF` one edge later.
- LB `xbpc=0x203` and LBU `xbpc=0x203`, data `0x80FF0011` → `dwb_sel=1000`; LB gives `mdat=0xFFFFFF80`, LBU gives `0x00000080`.
- SH, `xbpc=0x302`, `xdat=0xABCDABCD`, ack after 3 wait states → `dwb_adr=0x300`, `dwb_sel=1100`, `dwb_we=1`, `dstl` high 3 cycles with bus signals stable, `mdat` unchanged.
- LW `xbpc=0x101` and LH `xbpc=0x103` → no `dwb_stb`, `mexc=1` for one cycle each; `xfn3=3'b011` with LOAD → `mexc=1`.
- Assert `srst_n=0` mid-BUSY, then ack arrives after release → `dwb_stb=0` immediately, `mopc=0x0D`, stray ack ignored, `mdat=0`.
- Back-to-back SW `0x10` then LW `0x14`, zero-wait → two consecutive single-cycle strobes, `dstl` never high.
